// File: rtl/phase_seq_ctrl.sv
// Run controller for the five-phase output sequencer: dwell config file, run/stop control, loop counting.
// Optional `PHASE_SEQ_PAUSE_EN adds a pause input that freezes a run in place.
module phase_seq_ctrl #(
    parameter int CNT_W  = 4,
    parameter int LOOP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic              cfg_err,
    input  logic              start,
    input  logic              stop,
    input  logic [LOOP_W-1:0] loops,
    input  logic              en,
`ifdef PHASE_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase,
    output logic [1:0]        dout0,
    output logic [1:0]        dout1
);

    typedef enum logic [2:0] {
        S00  = 3'd0,
        S11  = 3'd1,
        S21  = 3'd2,
        S22  = 3'd3,
        S33  = 3'd4,
        IDLE = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;
    logic [LOOP_W-1:0]  loops_q, loops_d;
    logic [CNT_W-1:0]   dwell_q [5];
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               hold;
    logic               tick;
    logic [CNT_W-1:0]   cur_dwell;
    logic               phase_end;
    logic               last_loop;
    logic               cfg_ok;

`ifdef PHASE_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // A paused run sees no ticks; in IDLE ticks are never consumed, so pause is moot there.
    assign tick = en && !hold;

    always_comb begin
        cur_dwell = '0;
        case (state_q)
            S00:     cur_dwell = dwell_q[0];
            S11:     cur_dwell = dwell_q[1];
            S21:     cur_dwell = dwell_q[2];
            S22:     cur_dwell = dwell_q[3];
            S33:     cur_dwell = dwell_q[4];
            default: cur_dwell = '0;
        endcase
    end

    assign phase_end = tick && (cnt_q == cur_dwell - CNT_W'(1));
    assign last_loop = (loops_q != '0) && (loop_cnt_q == loops_q - LOOP_W'(1));

    assign cfg_ok    = (state_q == IDLE) && (cfg_addr <= 3'd4) && (cfg_data != '0);
    assign cfg_err_d = cfg_we && !cfg_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loop_cnt_d = loop_cnt_q;
        loops_d    = loops_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = S00;
                    cnt_d      = '0;
                    loop_cnt_d = '0;
                    loops_d    = loops;
                end
            end
            S00, S11, S21, S22, S33: begin
                // stop outranks a coincident phase end and suppresses done.
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (phase_end) begin
                    cnt_d = '0;
                    case (state_q)
                        S00:     state_d = S11;
                        S11:     state_d = S21;
                        S21:     state_d = S22;
                        S22:     state_d = S33;
                        default: begin
                            loop_cnt_d = loop_cnt_q + LOOP_W'(1);
                            if (last_loop) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S00;
                            end
                        end
                    endcase
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            loop_cnt_q <= '0;
            loops_q    <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loop_cnt_q <= loop_cnt_d;
            loops_q    <= loops_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q[0] <= CNT_W'(1);
            dwell_q[1] <= CNT_W'(2);
            dwell_q[2] <= CNT_W'(2);
            dwell_q[3] <= CNT_W'(2);
            dwell_q[4] <= CNT_W'(3);
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (cfg_we && cfg_ok && (cfg_addr == 3'(i))) begin
                    dwell_q[i] <= cfg_data;
                end
            end
        end
    end

    // Outputs decode the registered state only.
    assign busy    = (state_q != IDLE);
    assign phase   = state_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    always_comb begin
        dout0 = 2'd0;
        dout1 = 2'd0;
        case (state_q)
            S11:     begin dout0 = 2'd1; dout1 = 2'd1; end
            S21:     begin dout0 = 2'd1; dout1 = 2'd2; end
            S22:     begin dout0 = 2'd2; dout1 = 2'd2; end
            S33:     begin dout0 = 2'd3; dout1 = 2'd3; end
            default: begin dout0 = 2'd0; dout1 = 2'd0; end
        endcase
    end

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed scoreboard bench for phase_seq_ctrl; expected per-cycle traces are expanded from the dwell table.
module tb_phase_seq_ctrl;

    localparam int CNT_W  = 4;
    localparam int LOOP_W = 8;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              cfg_we   = 1'b0;
    logic [2:0]        cfg_addr = 3'd0;
    logic [CNT_W-1:0]  cfg_data = '0;
    logic              cfg_err;
    logic              start    = 1'b0;
    logic              stop     = 1'b0;
    logic [LOOP_W-1:0] loops    = '0;
    logic              en       = 1'b0;
`ifdef PHASE_SEQ_PAUSE_EN
    logic              pause    = 1'b0;
`endif
    logic              busy;
    logic              done;
    logic [2:0]        phase;
    logic [1:0]        dout0;
    logic [1:0]        dout1;

    phase_seq_ctrl #(.CNT_W(CNT_W), .LOOP_W(LOOP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .start    (start),
        .stop     (stop),
        .loops    (loops),
        .en       (en),
`ifdef PHASE_SEQ_PAUSE_EN
        .pause    (pause),
`endif
        .busy     (busy),
        .done     (done),
        .phase    (phase),
        .dout0    (dout0),
        .dout1    (dout1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       dn;
        logic       er;
    } exp_t;

    exp_t             sb [$];
    int               n_chk  = 0;
    int               n_pass = 0;
    logic [CNT_W-1:0] mdw [5];

    function automatic logic [1:0] exp_d0(input logic [2:0] ph);
        case (ph)
            3'd1, 3'd2: return 2'd1;
            3'd3:       return 2'd2;
            3'd4:       return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_d1(input logic [2:0] ph);
        case (ph)
            3'd1:       return 2'd1;
            3'd2, 3'd3: return 2'd2;
            3'd4:       return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    // Effective tick seen by the sequencer at edge k for each stimulus mode.
    function automatic bit en_at(input int mode, input int k);
        case (mode)
            1:       return (k % 2) == 1;
            2:       return !(k >= 2 && k <= 4);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " phase"}, 8'(phase), 8'(e.ph));
        chk({tag, " busy"},  8'(busy),  8'(e.ph != 3'd7));
        chk({tag, " done"},  8'(done),  8'(e.dn));
        chk({tag, " dout0"}, 8'(dout0), 8'(exp_d0(e.ph)));
        chk({tag, " dout1"}, 8'(dout1), 8'(exp_d1(e.ph)));
        chk({tag, " cfg_err"}, 8'(cfg_err), 8'(e.er));
    endtask

    task automatic push(input logic [2:0] ph, input logic dn, input logic er);
        exp_t e;
        e.ph = ph;
        e.dn = dn;
        e.er = er;
        sb.push_back(e);
    endtask

    task automatic set_default_dwells();
        mdw[0] = 4'd1; mdw[1] = 4'd2; mdw[2] = 4'd2; mdw[3] = 4'd2; mdw[4] = 4'd3;
    endtask

    // Expand a run into the value expected after each edge k (edge 0 = start sampled).
    task automatic gen(input int nloops, input int mode, input int stop_k, input int err_k);
        int k;
        int c;
        bit fin;
        k   = 0;
        fin = 1'b0;
        for (int l = 0; l < nloops && !fin; l++) begin
            for (int p = 0; p < 5 && !fin; p++) begin
                if (k == stop_k) begin
                    push(3'd7, 1'b0, k == err_k);
                    fin = 1'b1;
                end else begin
                    push(3'(p), 1'b0, k == err_k);
                    c = 0;
                    while (!fin && c < int'(mdw[p])) begin
                        k++;
                        if (en_at(mode, k)) c++;
                        if (c < int'(mdw[p])) begin
                            if (k == stop_k) begin
                                push(3'd7, 1'b0, k == err_k);
                                fin = 1'b1;
                            end else begin
                                push(3'(p), 1'b0, k == err_k);
                            end
                        end
                    end
                end
            end
        end
        if (!fin) push(3'd7, k != stop_k, k == err_k);
    endtask

    task automatic run(input string tag, input int loops_in, input int nloops, input int mode,
                       input int stop_k, input int err_k, input bit use_rst,
                       input int restart_k, input bit stop0);
        int n;
        gen(nloops, mode, stop_k, err_k);
        n = sb.size();
        for (int k = 0; k < n; k++) begin
            loops    = LOOP_W'(loops_in);
            start    = (k == 0) || (k == restart_k);
            stop     = (k == 0) ? stop0 : (k == stop_k && !use_rst);
            rst_n    = !(use_rst && k == stop_k);
            en       = (mode == 1) ? ((k % 2) == 1) : 1'b1;
`ifdef PHASE_SEQ_PAUSE_EN
            pause    = (mode == 2) && (k >= 2) && (k <= 4);
`endif
            cfg_we   = (k == err_k);
            cfg_addr = 3'd1;
            cfg_data = 4'd7;
            @(posedge clk);
            #1;
            start  = 1'b0;
            stop   = 1'b0;
            rst_n  = 1'b1;
            en     = 1'b0;
            cfg_we = 1'b0;
`ifdef PHASE_SEQ_PAUSE_EN
            pause  = 1'b0;
`endif
            pop_check($sformatf("%s e%0d", tag, k));
        end
    endtask

    task automatic idle_write(input string tag, input logic [2:0] a, input logic [CNT_W-1:0] d);
        logic ok;
        ok = (a <= 3'd4) && (d != '0);
        push(3'd7, 1'b0, !ok);
        push(3'd7, 1'b0, 1'b0);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        pop_check({tag, " w"});
        @(posedge clk);
        #1;
        pop_check({tag, " w+1"});
        if (ok) mdw[a] = d;
    endtask

    task automatic reset_cycle(input string tag);
        push(3'd7, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pop_check(tag);
        set_default_dwells();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        set_default_dwells();
        @(posedge clk);
        reset_cycle("reset");

        run("default", 1, 1, 0, -1, -1, 1'b0, -1, 1'b0);

        idle_write("cfg0", 3'd0, 4'd3);
        idle_write("cfg4", 3'd4, 4'd1);
        run("reprog", 2, 2, 0, -1, 4, 1'b0, -1, 1'b0);

        reset_cycle("reset2");
        run("engate", 1, 1, 1, -1, -1, 1'b0, -1, 1'b1);

        run("stop", 0, 3, 0, 16, -1, 1'b0, 3, 1'b0);
        run("restart", 1, 1, 0, -1, -1, 1'b0, -1, 1'b0);

        idle_write("badaddr", 3'd5, 4'd3);
        idle_write("baddata", 3'd2, 4'd0);
        run("after_bad", 1, 1, 0, -1, -1, 1'b0, -1, 1'b0);

        idle_write("cfg0b", 3'd0, 4'd3);
        run("rst_mid", 0, 3, 0, 10, -1, 1'b1, -1, 1'b0);
        set_default_dwells();
        run("post_rst", 1, 1, 0, -1, -1, 1'b0, -1, 1'b0);

`ifdef PHASE_SEQ_PAUSE_EN
        run("pause", 1, 1, 2, -1, -1, 1'b0, -1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
